// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
// State encoding, status-counter widths and a small constant helper.
package pll_sup_pkg;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer with synchronous active-low reset to 0.
// Used for PLL LOCK here and for the per-domain reset synchronizers.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a debounced lock with bounded
// retries, then releases domain resets in ascending order. Optional LOCK_LOSS_COUNT_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS         = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 4800,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 48000,
    parameter int unsigned STAGGER_CYCLES      = 64,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                   clkin,
    input  logic                   reset,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fault,
    output logic [RETRY_W-1:0]     retry_count,
    output logic [LOSS_W-1:0]      lock_loss_cnt
);

    localparam int unsigned RELEASE_SPAN = STAGGER_CYCLES * (NUM_DOMAINS - 1);
    localparam int unsigned CNT_MAX = max_u(max_u(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                            max_u(LOCK_TIMEOUT_CYCLES, RELEASE_SPAN));
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_SPAN);

    logic locked_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;

    sync_2ff #(
        .Width (1)
    ) u_lock_sync (
        .clk_i  (clkin),
        .rst_ni (reset),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        dom_d   = dom_q;
        ready_d = ready_q;
        retry_d = retry_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                end else begin
                    // Staggered release; cnt only climbs, so lower indices always go first.
                    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                        if (cnt_q == CNT_W'(i * STAGGER_CYCLES)) dom_d[i] = 1'b1;
                    end
                    if (cnt_q == RELEASE_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                        retry_d = '0;
                    end
                end
            end
            RUN: begin
                if (!locked_s) state_d = PLL_RST;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == RUN || state_q == FAULT) begin
            cnt_d = cnt_q;
        end

        // Outputs are registered from the next state so they change on the transition edge.
        pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
        fault_d   = (state_d == FAULT);
        if (pll_rst_d) begin
            dom_d   = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            retry_q   <= retry_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = dom_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign retry_count  = retry_q;

`ifdef LOCK_LOSS_COUNT_EN
    logic [LOSS_W-1:0] loss_q, loss_d;

    always_comb begin
        loss_d = loss_q;
        if ((state_q == RELEASE || state_q == RUN) && !locked_s && loss_q != '1) begin
            loss_d = loss_q + LOSS_W'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule
